ctrl_trace_recorder: RTL
========================

// Module: ctrl_trace_recorder
// PURPOSE
//  Hardware writer of control-unit test vectors: captures 23-bit records
//  {opcode[5:0], funct[5:0], Zero, RegWrite, RegDst, ALUSrc, MemWrite, MemtoReg,
//  Jump, PCSrc, alucontrol[2:0]} (MSB->LSB, same layout the vector-file benches read).
//  Buffers records in a FIFO and drains them over a valid/ready stream to a dump/trace sink.
//  Sits beside controlunit in the single-cycle MIPS core; turns live decode activity into replayable vectors.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, >=2
//  CNTW   16  width of rec_count / drop_count (saturating)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  start       in   1       begin recording session (pulse)
//  stop        in   1       end session, flush remaining records (pulse)
//  cap_valid   in   1       cap_vector valid this cycle
//  cap_vector  in   23      record to capture
//  out_valid   out  1       out_data holds a record
//  out_ready   in   1       sink accepts record
//  out_data    out  23      oldest buffered record
//  out_last    out  1       final record of session (FLUSH only)
//  busy        out  1       state != IDLE
//  overflow    out  1       sticky: >=1 record dropped this session
//  rec_count   out  CNTW    records accepted this session
//  drop_count  out  CNTW    records dropped (FIFO full)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-session discards all buffered records; no out_last is issued.
//  FSM: IDLE -start-> RECORD (clears rec_count, drop_count, overflow, FIFO).
//       RECORD -stop-> FLUSH. FLUSH -(last record handshaken, or FIFO empty)-> IDLE.
//       IDLE: stop ignored; start+stop same cycle = start. RECORD: start ignored; stop wins.
//       FLUSH: start, cap_valid ignored.
//  Capture: in RECORD, cap_valid=1 pushes cap_vector; a capture in the stop cycle is still taken.
//       Accepted if FIFO not full, or full with a pop in the same cycle (out_valid&&out_ready).
//       Otherwise dropped: drop_count+1, overflow<=1. Both counters saturate at all-ones.
//  Latency: a record pushed in cycle N is visible on out_data at N+1 at the earliest (registered FIFO read).
//  Stream: out_valid = FIFO non-empty && state in {RECORD, FLUSH}.
//       out_data is stable while out_valid && !out_ready; pop only on out_valid && out_ready. Strict FIFO order.
//  out_last=1 only in FLUSH, when exactly one entry remains; held with that record until handshake.
//       Then state -> IDLE the next cycle. FLUSH entered with empty FIFO -> IDLE in 1 cycle, no out_last.
//  Pointers use log2(DEPTH)+1 bits; full/empty derive from the wrap bit. Count is always 0..DEPTH.
// STRUCTURE
//  Package ctrl_trace_pkg: VEC_W=23; field offsets (OPC_MSB=22, FUNCT_MSB=16, ZERO_BIT=10,
//       REGWRITE_BIT=9 .. PCSRC_BIT=3, ALUC_MSB=2); typedef enum logic[1:0] {IDLE, RECORD, FLUSH} trace_state_t.
//  Sub-module: sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/count, same-cycle push+pop when full is legal, sync clear.
//  Top level holds the FSM, accept/drop logic, counters and out_last generation.
// TESTING
//  T1 reset: hold reset 2 cycles mid-stream -> all outputs 0, busy=0; next start gives rec_count=0.
//  T2 basic: start; 3 captures (lw 100011_000000_0_1010100010, sw, beq); stop; out_ready=1
//       -> same 3 vectors in order, out_last on 3rd only, busy=0 the cycle after it.
//  T3 backpressure: out_ready=0 for 5 cycles with 2 buffered -> out_data constant, no pop;
//       then ready=1 -> both delivered in order.
//  T4 overflow: DEPTH=16, ready=0, 20 captures -> rec_count=16, drop_count=4, overflow=1;
//       then 17th capture with ready=1 while full -> accepted.
//  T5 corner: start+stop in the same IDLE cycle -> RECORD. Capture in the stop cycle -> buffered.
//       Stop with an empty FIFO -> IDLE in 1 cycle, no out_valid.
//  T6 self-check: dump records to a .tv file, replay through the controlunit vector bench -> 0 errors.

Source files
------------

// File: rtl/ctrl_trace_pkg.sv
// Shared definitions for the control-unit trace recorder: the record layout
// and the recorder FSM state encoding.
package ctrl_trace_pkg;

  // Record layout, MSB->LSB: opcode, funct, Zero, RegWrite, RegDst, ALUSrc,
  // MemWrite, MemtoReg, Jump, PCSrc, alucontrol.
  localparam int VEC_W        = 23;
  localparam int OPC_MSB      = 22;
  localparam int FUNCT_MSB    = 16;
  localparam int ZERO_BIT     = 10;
  localparam int REGWRITE_BIT = 9;
  localparam int REGDST_BIT   = 8;
  localparam int ALUSRC_BIT   = 7;
  localparam int MEMWRITE_BIT = 6;
  localparam int MEMTOREG_BIT = 5;
  localparam int JUMP_BIT     = 4;
  localparam int PCSRC_BIT    = 3;
  localparam int ALUC_MSB     = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2
  } trace_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is taken when a
// pop happens in the same cycle. The read port is the registered storage
// slot at the read pointer, so a pushed word is readable the next cycle.
module sync_fifo
  import ctrl_trace_pkg::*;
#(
  parameter int WIDTH = VEC_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; clear and reset both empty the FIFO.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; the pointers define which
  // entries are valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/ctrl_trace_recorder.sv
// Records control-unit decode vectors into a FIFO during a session and
// drains them over a valid/ready stream, marking the final flushed record.
module ctrl_trace_recorder
  import ctrl_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_cap_valid,
  input  logic [VEC_W-1:0] i_cap_vector,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [VEC_W-1:0] o_out_data,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_overflow,
  output logic [CNTW-1:0]  o_rec_count,
  output logic [CNTW-1:0]  o_drop_count
);

  localparam int AW = $clog2(DEPTH);

  trace_state_t     r_state;
  trace_state_t     w_next_state;
  logic             w_clear;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_count;
  logic [VEC_W-1:0] w_fifo_dout;
  logic             w_capture;
  logic             w_accept;
  logic             w_drop;
  logic             r_overflow;
  logic [CNTW-1:0]  r_rec_count;
  logic [CNTW-1:0]  r_drop_count;

  assign w_pop     = o_out_valid && i_out_ready;
  assign w_capture = (r_state == RECORD) && i_cap_valid;
  assign w_accept  = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;
  assign w_push    = w_accept;

  sync_fifo #(.WIDTH(VEC_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_cap_vector),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and stream outputs.
  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned (which would infer a latch); blocking '=' is
  // correct here because this is combinational logic, not state.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    o_out_valid  = 1'b0;
    o_out_last   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = RECORD;
          w_clear      = 1'b1;
        end
      end
      RECORD: begin
        o_out_valid = !w_empty;
        if (i_stop) w_next_state = FLUSH;
      end
      FLUSH: begin
        o_out_valid = !w_empty;
        o_out_last  = (w_count == (AW+1)'(1));
        if (w_empty || (o_out_last && i_out_ready)) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Session counters and sticky overflow, cleared when a session starts.
  // NOTE: sequential state is updated with non-blocking '<=' only.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_rec_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept && (r_rec_count != '1))  r_rec_count  <= r_rec_count + CNTW'(1);
      if (w_drop && (r_drop_count != '1))   r_drop_count <= r_drop_count + CNTW'(1);
      if (w_drop)                           r_overflow   <= 1'b1;
    end
  end

  assign o_out_data   = o_out_valid ? w_fifo_dout : '0;
  assign o_busy       = (r_state != IDLE);
  assign o_overflow   = r_overflow;
  assign o_rec_count  = r_rec_count;
  assign o_drop_count = r_drop_count;

endmodule
